// File: rtl/hamming_secded_stream_decoder.sv
// hamming_secded_stream_decoder
//   Extended-Hamming (SECDED) decoder in a two-stage valid/ready pipeline
//   with full backpressure, plus saturating corrected/uncorrectable counters.
//
//   Codeword layout: in_code[0] is overall even parity; in_code[p] for
//   p >= 1 is Hamming position p. Power-of-two positions carry parity; data
//   bits occupy the remaining positions in ascending order, LSB first.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready input handshake, in_code = received codeword
//   out_valid/out_ready output handshake
//   out_data          corrected payload (uncorrected on out_err_uncorr)
//   out_syndrome      Hamming syndrome of the word
//   out_err_corr      single error corrected (including the overall-parity bit)
//   out_err_uncorr    double error or syndrome pointing past the codeword
//   cnt_clr           synchronous clear of both counters (wins over increment)
//   corr_cnt/uncorr_cnt saturating counts of flagged words delivered
//
// Handshake: a transfer happens on valid && ready at the rising clock edge.
//   The whole pipe advances together when adv = !out_valid || out_ready;
//   in_ready equals adv combinationally. While out_valid && !out_ready every
//   out_* field holds. Empty slots in stage 1 are squeezed out only when the
//   pipe advances.
module hamming_secded_stream_decoder #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8,
  // Smallest r with 2**r >= DATA_W + r + 1, unrolled for elaboration.
  localparam int PAR_W  = (DATA_W <= 1)   ? 2 :
                          (DATA_W <= 4)   ? 3 :
                          (DATA_W <= 11)  ? 4 :
                          (DATA_W <= 26)  ? 5 :
                          (DATA_W <= 57)  ? 6 :
                          (DATA_W <= 120) ? 7 : 8,
  localparam int CODE_W = DATA_W + PAR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [PAR_W-1:0]  out_syndrome,
  output logic              out_err_corr,
  output logic              out_err_uncorr,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic adv;
  logic out_fire;

  // Stage 1: raw code, syndrome, overall parity, occupancy.
  logic              s1_valid_q;
  logic [CODE_W-1:0] s1_code_q;
  logic [PAR_W-1:0]  s1_syn_q, s1_syn_d;
  logic              s1_par_q, s1_par_d;

  // Stage 2: delivered word.
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q, dec_data_d;
  logic [PAR_W-1:0]  out_syn_q;
  logic              out_corr_q, dec_corr_d;
  logic              out_uncorr_q, dec_uncorr_d;

  logic [CNT_W-1:0]  corr_cnt_q, corr_cnt_d;
  logic [CNT_W-1:0]  uncorr_cnt_q, uncorr_cnt_d;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;
  assign out_fire = out_valid_q && out_ready;

  // Syndrome is the XOR of the positions of all set bits; bit 0 has no
  // position weight and only enters the overall parity.
  always_comb begin
    s1_syn_d = '0;
    for (int p = 1; p < CODE_W; p++) begin
      if (in_code[p]) s1_syn_d = s1_syn_d ^ PAR_W'(p);
    end
    s1_par_d = ^in_code;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_code_q  <= '0;
      s1_syn_q   <= '0;
      s1_par_q   <= 1'b0;
    end else if (adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_code_q <= in_code;
        s1_syn_q  <= s1_syn_d;
        s1_par_q  <= s1_par_d;
      end
    end
  end

  // Classify, optionally flip the pointed-to bit, then gather data bits.
  always_comb begin
    logic [CODE_W-1:0] fixed;
    logic              flip;
    int                k;
    dec_corr_d   = 1'b0;
    dec_uncorr_d = 1'b0;
    dec_data_d   = '0;
    flip         = 1'b0;
    k            = 0;
    fixed        = s1_code_q;
    if (s1_syn_q == '0) begin
      // Only the overall-parity bit can be wrong; payload is untouched.
      dec_corr_d = s1_par_q;
    end else if (s1_par_q) begin
      if (int'(s1_syn_q) < CODE_W) begin
        dec_corr_d = 1'b1;
        flip       = 1'b1;
      end else begin
        // Syndrome names a position that a shortened code does not have.
        dec_uncorr_d = 1'b1;
      end
    end else begin
      dec_uncorr_d = 1'b1;
    end
    for (int p = 1; p < CODE_W; p++) begin
      if (flip && int'(s1_syn_q) == p) fixed[p] = ~fixed[p];
    end
    for (int p = 1; p < CODE_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        dec_data_d[k] = fixed[p];
        k = k + 1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_syn_q    <= '0;
      out_corr_q   <= 1'b0;
      out_uncorr_q <= 1'b0;
    end else if (adv) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_data_q   <= dec_data_d;
        out_syn_q    <= s1_syn_q;
        out_corr_q   <= dec_corr_d;
        out_uncorr_q <= dec_uncorr_d;
      end
    end
  end

  // Counters advance only when a flagged word is actually taken downstream.
  always_comb begin
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    if (cnt_clr) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
    end else if (out_fire) begin
      if (out_corr_q && corr_cnt_q != CNT_MAX)     corr_cnt_d   = corr_cnt_q + 1'b1;
      if (out_uncorr_q && uncorr_cnt_q != CNT_MAX) uncorr_cnt_d = uncorr_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign out_syndrome   = out_syn_q;
  assign out_err_corr   = out_corr_q;
  assign out_err_uncorr = out_uncorr_q;
  assign corr_cnt       = corr_cnt_q;
  assign uncorr_cnt     = uncorr_cnt_q;

endmodule

// File: tb/tb_hamming_secded_stream_decoder.sv
// Self-checking bench for hamming_secded_stream_decoder (DATA_W=4, CNT_W=8).
// Expected words come from the injected error pattern: encode clean data,
// flip 0/1/2 chosen positions, and state the outcome that pattern implies.
module tb_hamming_secded_stream_decoder;

  localparam int DATA_W = 4;
  localparam int PAR_W  = 3;
  localparam int CODE_W = 8;
  localparam int CNT_W  = 8;
  localparam int EXP_W  = DATA_W + PAR_W + 2;
  localparam int CNT_MAX = 255;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [CODE_W-1:0] in_code;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [PAR_W-1:0]  out_syndrome;
  logic              out_err_corr;
  logic              out_err_uncorr;
  logic              cnt_clr;
  logic [CNT_W-1:0]  corr_cnt;
  logic [CNT_W-1:0]  uncorr_cnt;

  always #5 clk = ~clk;

  hamming_secded_stream_decoder #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_syndrome(out_syndrome),
    .out_err_corr(out_err_corr), .out_err_uncorr(out_err_uncorr),
    .cnt_clr(cnt_clr), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [EXP_W-1:0] exp_q[$];
  int m_corr = 0;
  int m_uncorr = 0;
  bit rand_done;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [EXP_W-1:0] mk_exp(input logic [DATA_W-1:0] d, input logic [PAR_W-1:0] s,
                                              input logic c, input logic u);
    return {d, s, c, u};
  endfunction

  function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] c;
    int k;
    int s;
    c = '0; k = 0; s = 0;
    for (int p = 1; p < CODE_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p] = d[k];
        k++;
      end
    end
    for (int p = 1; p < CODE_W; p++) if (c[p]) s = s ^ p;
    for (int i = 0; i < PAR_W; i++) c[1 << i] = s[i];
    c[0] = ^c[CODE_W-1:1];
    return c;
  endfunction

  function automatic logic [DATA_W-1:0] extract(input logic [CODE_W-1:0] c);
    logic [DATA_W-1:0] d;
    int k;
    d = '0; k = 0;
    for (int p = 1; p < CODE_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[k] = c[p];
        k++;
      end
    end
    return d;
  endfunction

  // nflip < 0 picks 0..2 at random.
  task automatic gen_word(input int nflip, output logic [CODE_W-1:0] code, output logic [EXP_W-1:0] e);
    logic [DATA_W-1:0] d;
    int n, a, b;
    d = DATA_W'($urandom_range(0, 15));
    n = (nflip < 0) ? int'($urandom_range(0, 2)) : nflip;
    a = $urandom_range(0, CODE_W - 1);
    b = (a + int'($urandom_range(1, CODE_W - 1))) % CODE_W;
    code = encode(d);
    if (n == 0) begin
      e = mk_exp(d, '0, 1'b0, 1'b0);
    end else if (n == 1) begin
      code[a] = ~code[a];
      e = mk_exp(d, PAR_W'(a), 1'b1, 1'b0);
    end else begin
      code[a] = ~code[a];
      code[b] = ~code[b];
      e = mk_exp(extract(code), PAR_W'(a ^ b), 1'b0, 1'b1);
    end
  endtask

  // ---------------- driver ----------------
  // Entered just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [CODE_W-1:0] code, input logic [EXP_W-1:0] e);
    bit accepted;
    accepted = 1'b0;
    in_valid = 1'b1;
    in_code  = code;
    for (int t = 0; t < 200 && !accepted; t++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        accepted = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!accepted) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for code %0h", code);
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && exp_q.size() > 0; t++) @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  // ---------------- scoreboard / compare process ----------------
  bit               stalled = 1'b0;
  logic [EXP_W-1:0] held;

  always @(negedge clk) begin
    logic [EXP_W-1:0] got;
    logic [EXP_W-1:0] e;
    bit fire;
    if (!rst_n) begin
      exp_q.delete();
      m_corr   = 0;
      m_uncorr = 0;
      stalled  = 1'b0;
    end else begin
      got  = {out_data, out_syndrome, out_err_corr, out_err_uncorr};
      e    = '0;
      fire = out_valid && out_ready;
      check("in_ready_rule", in_ready, !out_valid || out_ready);
      if (stalled) begin
        check("stall_valid_held", out_valid, 1);
        check("stall_fields_held", got, held);
      end
      stalled = out_valid && !out_ready;
      held    = got;
      check("corr_cnt", corr_cnt, m_corr);
      check("uncorr_cnt", uncorr_cnt, m_uncorr);
      if (out_valid && out_err_corr && out_err_uncorr) check("flags_exclusive", 1, 0);
      if (fire) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_output: got %0h with no word outstanding", got);
        end else begin
          e = exp_q.pop_front();
          check("out_word", got, e);
        end
      end
      if (cnt_clr) begin
        m_corr   = 0;
        m_uncorr = 0;
      end else if (fire) begin
        if (e[1] && m_corr < CNT_MAX)   m_corr++;
        if (e[0] && m_uncorr < CNT_MAX) m_uncorr++;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [CODE_W-1:0] c;
    logic [EXP_W-1:0]  e;
    rst_n = 1'b0; in_valid = 1'b0; in_code = '0; out_ready = 1'b0; cnt_clr = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_data", out_data, 0);
    check("rst_syndrome", out_syndrome, 0);
    check("rst_flags", {out_err_corr, out_err_uncorr}, 0);
    check("rst_counters", {corr_cnt, uncorr_cnt}, 0);
    #2 rst_n = 1'b1;

    // Pin the model against hand-worked values.
    check("model_encode_B", encode(4'hB), 8'hAA);
    check("model_extract_CA", extract(8'hCA), 4'hD);

    @(posedge clk); #1;
    out_ready = 1'b1;

    // Clean word and two-cycle latency.
    send(8'hAA, mk_exp(4'hB, 3'd0, 1'b0, 1'b0));
    check("latency_cycle1", out_valid, 0);
    @(posedge clk); #1;
    check("latency_cycle2", out_valid, 1);
    check("latency_data", out_data, 4'hB);

    send(8'h8A, mk_exp(4'hB, 3'd5, 1'b1, 1'b0));
    send(8'hAB, mk_exp(4'hB, 3'd0, 1'b1, 1'b0));
    send(8'hCA, mk_exp(4'hD, 3'd3, 1'b0, 1'b1));
    drain();
    check("directed_corr_cnt", corr_cnt, 2);
    check("directed_uncorr_cnt", uncorr_cnt, 1);

    // Four-word stream with a three-cycle stall mid-stream.
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          gen_word(-1, c, e);
          send(c, e);
        end
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("stall_in_ready", in_ready, 0);
        @(posedge clk);
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two words in flight.
    gen_word(1, c, e); send(c, e);
    gen_word(2, c, e); send(c, e);
    check("pre_reset_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("reset_now_valid", out_valid, 0);
    check("reset_now_in_ready", in_ready, 1);
    check("reset_now_data", out_data, 0);
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_reset_valid", out_valid, 0);
    check("post_reset_counters", {corr_cnt, uncorr_cnt}, 0);

    // Saturation of the corrected counter.
    for (int i = 0; i < 300; i++) begin
      gen_word(1, c, e);
      send(c, e);
    end
    drain();
    check("sat_corr_cnt", corr_cnt, 255);

    // Clear wins over a same-cycle increment.
    cnt_clr = 1'b1;
    gen_word(1, c, e);
    send(c, e);
    repeat (3) @(posedge clk);
    #1 cnt_clr = 1'b0;
    check("clr_corr_cnt", corr_cnt, 0);

    // Randomised traffic with random backpressure and occasional clears.
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            in_code = CODE_W'($urandom);
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
          gen_word(-1, c, e);
          send(c, e);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          out_ready = ($urandom_range(0, 9) < 7);
          cnt_clr   = ($urandom_range(0, 49) == 0);
          @(posedge clk);
          #1;
        end
      end
    join
    out_ready = 1'b1;
    cnt_clr   = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
